// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_capture
// Brief    : N-channel GPIO input front-end: synchroniser, debounce, edge
//            detect, saturating edge counters, sticky flags and masked irq.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_in_capture #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8,
  parameter int SEL_W       = 5
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [N-1:0]     gpio_in,
  input  logic [1:0]       edge_mode,
  input  logic             clear,
  input  logic [N-1:0]     irq_mask,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [N-1:0]     level,
  output logic [N-1:0]     edge_pulse,
  output logic [N-1:0]     sticky,
  output logic [N-1:0]     ovf,
  output logic [CNT_W-1:0] rd_count,
  output logic             irq
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [N-1:0]     r_sync [SYNC_STAGES];
  logic [N-1:0]     w_sync;
  logic [N-1:0]     w_level_nxt;
  logic [N-1:0]     r_level;
  logic [N-1:0]     r_edge_pulse;
  logic [N-1:0]     r_sticky;
  logic [N-1:0]     r_ovf;
  logic [CNT_W-1:0] r_cnt [N];
  logic [CNT_W-1:0] w_rd_val;
  logic [CNT_W-1:0] r_rd_count;
  logic             r_irq;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_db_bypass
      assign w_level_nxt = w_sync;
    end else begin : g_db
      localparam int                c_DB_W    = $clog2(DEBOUNCE + 1);
      localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);

      for (genvar i = 0; i < N; i++) begin : g_ch
        logic [c_DB_W-1:0] r_db;

        // Counts consecutive cycles the synchronised pin disagrees with level.
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
          if (!resetn) begin
            r_db <= '0;
          end else if (w_sync[i] == r_level[i]) begin
            r_db <= '0;
          end else if (r_db == c_DB_LAST) begin
            r_db <= '0;
          end else begin
            r_db <= r_db + c_DB_W'(1);
          end
        end

        assign w_level_nxt[i] = ((w_sync[i] != r_level[i]) && (r_db == c_DB_LAST))
                                ? w_sync[i] : r_level[i];
      end
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_level      <= '0;
      r_edge_pulse <= '0;
    end else begin
      r_level      <= w_level_nxt;
      r_edge_pulse <= (~r_level &  w_level_nxt & {N{edge_mode[0]}}) |
                      ( r_level & ~w_level_nxt & {N{edge_mode[1]}});
    end
  end

  // An edge coinciding with clear survives as the first event after the clear.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
      r_sticky <= '0;
      r_ovf    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_edge_pulse[i]) begin
          r_sticky[i] <= 1'b1;
          if (clear) begin
            r_cnt[i] <= CNT_W'(1);
            r_ovf[i] <= 1'b0;
          end else if (r_cnt[i] != c_CNT_MAX) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end else begin
            r_ovf[i] <= 1'b1;
          end
        end else if (clear) begin
          r_cnt[i]    <= '0;
          r_sticky[i] <= 1'b0;
          r_ovf[i]    <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        w_rd_val = r_cnt[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_rd_count <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_count <= w_rd_val;
      r_irq      <= |(r_sticky & irq_mask);
    end
  end

  assign level      = r_level;
  assign edge_pulse = r_edge_pulse;
  assign sticky     = r_sticky;
  assign ovf        = r_ovf;
  assign rd_count   = r_rd_count;
  assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_in_capture
// Brief    : Self-checking bench; two instances (8-bit and 4-bit counters)
//            share stimulus and are compared against a sample-window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_in_capture;

  localparam int N     = 4;
  localparam int S     = 2;
  localparam int D     = 4;
  localparam int SEL_W = 5;

  logic             clk    = 1'b0;
  logic             resetn = 1'b0;
  logic [N-1:0]     gpio_in   = '0;
  logic [N-1:0]     irq_mask  = '0;
  logic [1:0]       edge_mode = 2'b00;
  logic             clear     = 1'b0;
  logic [SEL_W-1:0] rd_sel    = '0;

  logic [N-1:0] level8, pulse8, sticky8, ovf8;
  logic [N-1:0] level4, pulse4, sticky4, ovf4;
  logic [7:0]   rd8;
  logic [3:0]   rd4;
  logic         irq8, irq4;

  always #5 clk = ~clk;

  gpio_in_capture #(.N(N), .SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(8), .SEL_W(SEL_W)) u_dut8 (
    .CLOCK_50(clk), .resetn(resetn), .gpio_in(gpio_in), .edge_mode(edge_mode),
    .clear(clear), .irq_mask(irq_mask), .rd_sel(rd_sel), .level(level8),
    .edge_pulse(pulse8), .sticky(sticky8), .ovf(ovf8), .rd_count(rd8), .irq(irq8)
  );

  gpio_in_capture #(.N(N), .SYNC_STAGES(S), .DEBOUNCE(D), .CNT_W(4), .SEL_W(SEL_W)) u_dut4 (
    .CLOCK_50(clk), .resetn(resetn), .gpio_in(gpio_in), .edge_mode(edge_mode),
    .clear(clear), .irq_mask(irq_mask), .rd_sel(rd_sel), .level(level4),
    .edge_pulse(pulse4), .sticky(sticky4), .ovf(ovf4), .rd_count(rd4), .irq(irq4)
  );

  // Reference model: level flips once the last D synchronised samples all
  // disagree with it; hist[j] is the pin value sampled j+1 edges ago.
  logic [N-1:0] m_hist [S+D];
  logic [N-1:0] m_level, m_pulse, m_sticky, m_ovf8, m_ovf4, m_nl;
  int           m_cnt8 [N];
  int           m_cnt4 [N];
  int           m_rd8, m_rd4;
  logic         m_irq;
  bit           m_all;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < S + D; k++) m_hist[k] = '0;
      for (int i = 0; i < N; i++) begin
        m_cnt8[i] = 0;
        m_cnt4[i] = 0;
      end
      m_level = '0; m_pulse = '0; m_sticky = '0; m_ovf8 = '0; m_ovf4 = '0;
      m_rd8 = 0; m_rd4 = 0; m_irq = 1'b0;
    end else begin
      m_rd8 = 0;
      m_rd4 = 0;
      for (int i = 0; i < N; i++) begin
        if (int'(rd_sel) == i) begin
          m_rd8 = m_cnt8[i];
          m_rd4 = m_cnt4[i];
        end
      end
      m_irq = |(m_sticky & irq_mask);
      for (int i = 0; i < N; i++) begin
        if (m_pulse[i]) begin
          m_sticky[i] = 1'b1;
          if (clear) begin
            m_cnt8[i] = 1; m_cnt4[i] = 1; m_ovf8[i] = 1'b0; m_ovf4[i] = 1'b0;
          end else begin
            if (m_cnt8[i] < 255) m_cnt8[i] = m_cnt8[i] + 1; else m_ovf8[i] = 1'b1;
            if (m_cnt4[i] < 15)  m_cnt4[i] = m_cnt4[i] + 1; else m_ovf4[i] = 1'b1;
          end
        end else if (clear) begin
          m_cnt8[i] = 0; m_cnt4[i] = 0; m_sticky[i] = 1'b0;
          m_ovf8[i] = 1'b0; m_ovf4[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        m_all = 1'b1;
        for (int k = S - 1; k <= S + D - 2; k++) begin
          if (m_hist[k][i] == m_level[i]) m_all = 1'b0;
        end
        m_nl[i] = m_all ? ~m_level[i] : m_level[i];
      end
      m_pulse = (~m_level & m_nl & {N{edge_mode[0]}}) | (m_level & ~m_nl & {N{edge_mode[1]}});
      m_level = m_nl;
      for (int k = S + D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = gpio_in;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level8",  32'(level8),  32'(m_level));
      check("model_level4",  32'(level4),  32'(m_level));
      check("model_pulse8",  32'(pulse8),  32'(m_pulse));
      check("model_pulse4",  32'(pulse4),  32'(m_pulse));
      check("model_sticky8", 32'(sticky8), 32'(m_sticky));
      check("model_sticky4", 32'(sticky4), 32'(m_sticky));
      check("model_ovf8",    32'(ovf8),    32'(m_ovf8));
      check("model_ovf4",    32'(ovf4),    32'(m_ovf4));
      check("model_rd8",     32'(rd8),     32'(m_rd8));
      check("model_rd4",     32'(rd4),     32'(m_rd4));
      check("model_irq8",    32'(irq8),    32'(m_irq));
      check("model_irq4",    32'(irq4),    32'(m_irq));
    end
  end

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         toggles;
    int         exp_rd;
  } em_vec_t;

  em_vec_t em_tab [4];
  bit      seen;

  initial begin
    em_tab[0] = '{2'b00, 5, 0};
    em_tab[1] = '{2'b01, 5, 3};
    em_tab[2] = '{2'b10, 5, 2};
    em_tab[3] = '{2'b11, 5, 5};

    // Reset with all pins high, then release and time the level change
    edge_mode = 2'b01;
    gpio_in   = 4'hF;
    wait_cycles(3);
    chk_en = 1'b1;
    check("rst_outputs8", 32'({level8, pulse8, sticky8, ovf8, rd8, irq8}), 32'h0);
    check("rst_outputs4", 32'({level4, pulse4, sticky4, ovf4, rd4, irq4}), 32'h0);
    resetn = 1'b1;
    wait_cycles(5);
    check("rst_level_edge5", 32'(level8), 32'h0);
    wait_cycles(1);
    check("rst_level_edge6", 32'(level8), 32'hF);
    check("rst_pulse_edge6", 32'(pulse8), 32'hF);
    wait_cycles(1);
    check("rst_pulse_edge7", 32'(pulse8), 32'h0);
    gpio_in = '0;
    wait_cycles(12);

    // Glitch rejection on channel 1
    edge_mode = 2'b11;
    do_clear();
    rd_sel = 5'd1;
    gpio_in[1] = 1'b1;
    wait_cycles(3);
    gpio_in[1] = 1'b0;
    wait_cycles(14);
    check("glitch3_rd",     32'(rd8),     0);
    check("glitch3_sticky", 32'(sticky8), 0);
    seen = 1'b0;
    gpio_in[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (level8[1]) seen = 1'b1;
    end
    gpio_in[1] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (level8[1]) seen = 1'b1;
    end
    check("glitch4_level_seen", 32'(seen),      1);
    check("glitch4_level_back", 32'(level8[1]), 0);
    check("glitch4_rd8",        32'(rd8),       2);
    check("glitch4_rd4",        32'(rd4),       2);

    // Edge-mode table on channel 0
    for (int v = 0; v < 4; v++) begin
      edge_mode = em_tab[v].mode;
      do_clear();
      rd_sel = 5'd0;
      for (int t = 0; t < em_tab[v].toggles; t++) begin
        gpio_in[0] = ~gpio_in[0];
        wait_cycles(8);
      end
      wait_cycles(4);
      check($sformatf("edge_mode_%0d_rd8", v), 32'(rd8), em_tab[v].exp_rd);
      check($sformatf("edge_mode_%0d_rd4", v), 32'(rd4), em_tab[v].exp_rd);
      gpio_in[0] = 1'b0;
      wait_cycles(10);
    end

    // Saturation on channel 2 of the 4-bit instance
    edge_mode = 2'b01;
    do_clear();
    rd_sel = 5'd2;
    for (int e = 1; e <= 16; e++) begin
      gpio_in[2] = 1'b1;
      wait_cycles(8);
      gpio_in[2] = 1'b0;
      wait_cycles(8);
      if (e == 15) begin
        check("sat15_rd4",  32'(rd4),     15);
        check("sat15_ovf4", 32'(ovf4[2]), 0);
      end
      if (e == 16) begin
        check("sat16_rd4",  32'(rd4),     15);
        check("sat16_ovf4", 32'(ovf4[2]), 1);
        check("sat16_rd8",  32'(rd8),     16);
        check("sat16_ovf8", 32'(ovf8[2]), 0);
      end
    end

    // Clear colliding with an edge pulse on channel 3
    do_clear();
    rd_sel = 5'd3;
    for (int e = 0; e < 7; e++) begin
      gpio_in[3] = 1'b1;
      wait_cycles(8);
      gpio_in[3] = 1'b0;
      wait_cycles(8);
    end
    check("coll_pre_rd8", 32'(rd8), 7);
    gpio_in[3] = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (pulse8[3]) seen = 1'b1;
    end
    check("coll_pulse_seen", 32'(seen), 1);
    do_clear();
    check("coll_sticky", 32'(sticky8), 32'h8);
    check("coll_ovf",    32'(ovf8[3]), 0);
    wait_cycles(1);
    check("coll_rd8", 32'(rd8), 1);
    check("coll_rd4", 32'(rd4), 1);
    rd_sel = 5'd6;
    wait_cycles(2);
    check("rdsel6_rd8", 32'(rd8), 0);
    check("rdsel6_rd4", 32'(rd4), 0);
    gpio_in[3] = 1'b0;
    wait_cycles(10);

    // Interrupt masking, then asynchronous reset mid-cycle
    edge_mode = 2'b11;
    do_clear();
    irq_mask = 4'b0100;
    rd_sel   = 5'd2;
    gpio_in[0] = 1'b1;
    wait_cycles(10);
    gpio_in[0] = 1'b0;
    wait_cycles(10);
    check("irq_masked",        32'(irq8),    0);
    check("irq_masked_sticky", 32'(sticky8), 32'h1);
    gpio_in[2] = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (sticky8[2]) seen = 1'b1;
    end
    check("irq_sticky_seen", 32'(seen), 1);
    check("irq_same_cycle",  32'(irq8), 0);
    wait_cycles(1);
    check("irq_next_cycle8", 32'(irq8), 1);
    check("irq_next_cycle4", 32'(irq4), 1);
    wait_cycles(3);
    check("pre_arst_rd8", 32'(rd8), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_irq",    32'(irq8),    0);
    check("arst_sticky", 32'(sticky8), 0);
    check("arst_rd8",    32'(rd8),     0);
    check("arst_level",  32'(level8),  0);
    gpio_in = '0;
    wait_cycles(2);
    resetn = 1'b1;
    wait_cycles(3);
    check("post_arst_rd8", 32'(rd8), 0);

    // Randomised traffic checked against the model
    irq_mask = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) gpio_in[i] = ~gpio_in[i];
      end
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) edge_mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) irq_mask = 4'($urandom);
      rd_sel = 5'($urandom_range(0, 7));
    end
    clear = 1'b0;
    wait_cycles(3);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
